// File: rtl/mem_stage_ctrl_pkg.sv
// Shared bus widths, load-type codes and the EX->MEM bus layout for the MEM stage.
package mem_stage_ctrl_pkg;

  localparam int ES_TO_MS_LEN   = 75;
  localparam int MS_TO_WS_LEN   = 71;
  localparam int MEM_BYPASS_LEN = 39;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic [2:0]  mem_type;
    logic        res_from_csr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } es_bus_t;

endpackage

// File: rtl/mem_stage_ctrl_load_aligner.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_aligner
  import mem_stage_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_mem_type,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_result = i_rdata;
    case (i_mem_type)
      LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_result = {24'h000000, w_byte};
      LD_H:    o_result = {{16{w_half[15]}}, w_half};
      LD_HU:   o_result = {16'h0000, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: load-response capture, stale-response discard after flush,
// result selection and valid/allowin handshake towards WB.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      es_to_ms_valid,
  output logic                      ms_allowin,
  input  logic [ES_TO_MS_LEN-1:0]   es_to_ms_bus,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata,
  input  logic                      flush,
  input  logic                      ws_allowin,
  output logic                      ms_to_ws_valid,
  output logic [MS_TO_WS_LEN-1:0]   ms_to_ws_bus,
  output logic [MEM_BYPASS_LEN-1:0] MEM_bypass_bus
);

  localparam logic [DISCARD_W-1:0] DISCARD_ONE = {{(DISCARD_W-1){1'b0}}, 1'b1};

  es_bus_t              r_es_bus;
  logic                 r_ms_valid;
  logic                 r_data_got;
  logic [31:0]          r_rdata_buf;
  logic [DISCARD_W-1:0] r_discard_cnt;

  logic        w_ready_go;
  logic        w_accept;
  logic        w_wait_data;
  logic        w_discard_idle;
  logic        w_capture;
  logic        w_discard_inc;
  logic        w_discard_dec;
  logic        w_not_ready;
  logic [31:0] w_aligned;
  logic [31:0] w_final_result;

  assign w_ready_go     = !r_es_bus.res_from_mem | r_data_got;
  assign ms_allowin     = !r_ms_valid | (w_ready_go & ws_allowin);
  assign w_accept       = es_to_ms_valid & ms_allowin & !flush;
  assign w_wait_data    = r_ms_valid & r_es_bus.res_from_mem & !r_data_got;
  assign w_discard_idle = (r_discard_cnt == '0);
  assign w_capture      = data_sram_data_ok & w_discard_idle & w_wait_data;
  assign w_discard_dec  = data_sram_data_ok & !w_discard_idle;
  // a flushed load still owed its response leaves one stale response in flight
  assign w_discard_inc  = flush & w_wait_data & !w_capture;

  load_aligner u_load_aligner (
    .i_rdata    (r_rdata_buf),
    .i_addr     (r_es_bus.alu_result[1:0]),
    .i_mem_type (r_es_bus.mem_type),
    .o_result   (w_aligned)
  );

  assign w_final_result = r_es_bus.res_from_mem ? w_aligned : r_es_bus.alu_result;
  assign w_not_ready    = w_wait_data | (r_ms_valid & r_es_bus.res_from_csr);

  assign ms_to_ws_valid = r_ms_valid & w_ready_go & !flush;
  assign ms_to_ws_bus   = {r_es_bus.pc, r_es_bus.res_from_csr, r_es_bus.rf_we,
                           r_es_bus.rf_waddr, w_final_result};
  assign MEM_bypass_bus = {w_not_ready, r_es_bus.rf_waddr,
                           r_ms_valid & r_es_bus.rf_we, w_final_result};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid  <= 1'b0;
      r_es_bus    <= '0;
      r_data_got  <= 1'b0;
      r_rdata_buf <= 32'h0;
    end else begin
      if (flush)
        r_ms_valid <= 1'b0;
      else if (w_accept)
        r_ms_valid <= 1'b1;
      else if (ms_allowin)
        r_ms_valid <= 1'b0;

      if (w_accept) begin
        r_es_bus   <= es_bus_t'(es_to_ms_bus);
        r_data_got <= 1'b0;
      end else if (w_capture) begin
        r_data_got  <= 1'b1;
        r_rdata_buf <= data_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_discard_cnt <= '0;
    end else begin
      case ({w_discard_inc, w_discard_dec})
        2'b10:   r_discard_cnt <= r_discard_cnt + DISCARD_ONE;
        2'b01:   r_discard_cnt <= r_discard_cnt - DISCARD_ONE;
        default: r_discard_cnt <= r_discard_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases plus random traffic against a queue-based model.
module tb_mem_stage_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         es_to_ms_valid;
  logic         ms_allowin;
  logic [74:0]  es_to_ms_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [70:0]  ms_to_ws_bus;
  logic [38:0]  MEM_bypass_bus;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .MEM_bypass_bus    (MEM_bypass_bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ld;
    logic [2:0]  mt;
    logic        csr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] rd;
  } inst_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          ready_at;
    bit          stale;
  } resp_t;

  resp_t       resp_q[$];
  logic [70:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          occ = 0;
  bit          have = 0;
  inst_t       occ_i;
  int          occ_id = 0;
  int          next_id = 0;
  inst_t       idle;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic inst_t mk(input logic ld, input logic [2:0] mt, input logic csr,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] alu, input logic [31:0] rd);
    inst_t i;
    i.pc = $urandom(); i.ld = ld; i.mt = mt; i.csr = csr; i.we = we;
    i.wa = wa; i.alu = alu; i.rd = rd;
    return i;
  endfunction

  function automatic inst_t rnd_inst();
    logic ld;
    ld = 1'($urandom_range(0, 1));
    return mk(ld, 3'($urandom_range(0, 7)), !ld && ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(), $urandom());
  endfunction

  function automatic logic [74:0] pack(input inst_t i);
    return {i.pc, i.ld, i.mt, i.csr, i.we, i.wa, i.alu};
  endfunction

  // Reference load result from the architectural rules
  function automatic logic [31:0] result_of(input inst_t i);
    logic [31:0] b, h;
    if (!i.ld) return i.alu;
    b = (i.rd >> (8 * i.alu[1:0])) & 32'hFF;
    h = (i.rd >> (16 * i.alu[1])) & 32'hFFFF;
    case (i.mt)
      3'b000:  return b | ((b >= 32'd128) ? 32'hFFFFFF00 : 32'h0);
      3'b001:  return h | ((h >= 32'd32768) ? 32'hFFFF0000 : 32'h0);
      3'b100:  return b;
      3'b101:  return h;
      default: return i.rd;
    endcase
  endfunction

  function automatic logic [70:0] exp_bus(input inst_t i);
    return {i.pc, i.csr, i.we, i.wa, result_of(i)};
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (resp_q[k]) if (resp_q[k].stale) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance the model.
  task automatic step(input bit v, input inst_t in, input bit ok_en, input bit wsa, input bit fl);
    bit    ok, ready, allow, got_live;
    resp_t r;
    @(negedge clk);
    ok = ok_en && (resp_q.size() > 0) && (resp_q[0].ready_at <= cyc);
    es_to_ms_valid    = v;
    es_to_ms_bus      = pack(in);
    data_sram_data_ok = ok;
    data_sram_rdata   = ok ? resp_q[0].data : $urandom();
    flush             = fl;
    ws_allowin        = wsa;
    #1;
    ready = !occ_i.ld || have;
    allow = !occ || (ready && wsa);
    chk("ms_allowin", ms_allowin, allow);
    chk("ms_to_ws_valid", ms_to_ws_valid, occ && ready && !fl);
    chk("not_ready", MEM_bypass_bus[38], occ && (occ_i.csr || (occ_i.ld && !have)));
    chk("rf_we_valid", MEM_bypass_bus[32], occ && occ_i.we);
    if (occ) chk("bypass_waddr", MEM_bypass_bus[37:33], occ_i.wa);
    if (occ && ready) chk("bypass_result", MEM_bypass_bus[31:0], result_of(occ_i));

    got_live = 0;
    if (ok) begin
      r = resp_q.pop_front();
      if (occ && occ_i.ld && !have && r.id == occ_id) begin
        have = 1;
        got_live = 1;
      end
      assert (r.stale || got_live) else $error("protocol: data_ok with no waiting load");
    end
    if (fl) begin
      if (occ) begin
        void'(exp_q.pop_back());
        if (occ_i.ld && !have)
          foreach (resp_q[k]) if (resp_q[k].id == occ_id) resp_q[k].stale = 1;
      end
      occ = 0;
      assert (stale_cnt() <= 3) else $error("protocol: more than 3 stale responses");
    end else if (v && allow) begin
      occ    = 1;
      occ_i  = in;
      occ_id = next_id++;
      have   = 0;
      if (in.ld) resp_q.push_back('{id: occ_id, data: in.rd, ready_at: cyc + 1, stale: 1'b0});
      exp_q.push_back(exp_bus(in));
    end else if (allow) begin
      occ = 0;
    end
    cyc++;
  endtask

  task automatic ld_case(input string nm, input logic [2:0] mt, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] expv);
    step(0, idle, 1, 1, 0);
    step(1, mk(1, mt, 0, 1, 5'd7, addr, rd), 0, 1, 0);
    step(0, idle, 1, 1, 0);
    step(0, idle, 0, 1, 0);
    chk({nm, "_valid"}, ms_to_ws_valid, 1'b1);
    chk(nm, ms_to_ws_bus[31:0], expv);
  endtask

  // Monitor: every WB handoff pops the oldest expected result
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn === 1'b1 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got bus %h expected no handoff", ms_to_ws_bus);
        end else begin
          chk("wb_bus", ms_to_ws_bus, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    inst_t cur;
    bit    have_cur;
    int    id0;
    bit    fl;

    idle = mk(0, 3'd0, 0, 0, 5'd0, 32'h0, 32'h0);
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0; flush = 1'b0; ws_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ws_bus", ms_to_ws_bus, 71'h0);
    chk("rst_bypass", MEM_bypass_bus, 39'h0);
    @(negedge clk);
    resetn = 1'b1;

    // ALU op, single-cycle pass-through
    step(0, idle, 0, 1, 0);
    step(1, mk(0, 3'd0, 0, 1, 5'd5, 32'h00001234, 32'h0), 0, 1, 0);
    step(0, idle, 0, 1, 0);
    chk("alu_bypass", MEM_bypass_bus, {1'b0, 5'd5, 1'b1, 32'h00001234});
    chk("alu_result", ms_to_ws_bus[31:0], 32'h00001234);

    ld_case("ld_b",  3'b000, 32'h00001003, 32'h80FF0000, 32'hFFFFFF80);
    ld_case("ld_bu", 3'b100, 32'h00001003, 32'h80FF0000, 32'h00000080);
    ld_case("ld_hu", 3'b101, 32'h00001002, 32'h80FF0000, 32'h000080FF);
    ld_case("ld_h",  3'b001, 32'h00001002, 32'h80FF0000, 32'hFFFF80FF);

    // ld.w with a 3-cycle late response
    step(0, idle, 1, 1, 0);
    step(1, mk(1, 3'b010, 0, 1, 5'd9, 32'h00002000, 32'hCAFEF00D), 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, idle, 0, 1, 0);
      chk("wait_allowin", ms_allowin, 1'b0);
      chk("wait_not_ready", MEM_bypass_bus[38], 1'b1);
    end
    step(0, idle, 1, 1, 0);
    step(0, idle, 0, 1, 0);
    chk("late_not_ready", MEM_bypass_bus[38], 1'b0);
    chk("late_result", MEM_bypass_bus[31:0], 32'hCAFEF00D);

    // response arrives while WB stalls
    step(0, idle, 1, 1, 0);
    step(1, mk(1, 3'b010, 0, 1, 5'd3, 32'h00003000, 32'h5A5AC3C3), 0, 1, 0);
    step(0, idle, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, idle, 0, 0, 0);
      chk("stall_valid", ms_to_ws_valid, 1'b1);
      chk("stall_result", ms_to_ws_bus[31:0], 32'h5A5AC3C3);
    end
    step(0, idle, 0, 1, 0);
    chk("release_result", ms_to_ws_bus[31:0], 32'h5A5AC3C3);
    step(0, idle, 0, 1, 0);
    chk("release_empty", ms_to_ws_valid, 1'b0);

    // flush a pending load, then a new load must skip the stale response
    step(1, mk(1, 3'b010, 0, 1, 5'd4, 32'h00004000, 32'hDEADBEEF), 0, 1, 0);
    step(0, idle, 0, 1, 1);
    step(1, mk(1, 3'b010, 0, 1, 5'd6, 32'h00005000, 32'h11111111), 0, 1, 0);
    chk("discard_after_flush", dut.r_discard_cnt, 2'd1);
    step(0, idle, 1, 1, 0);
    chk("discard_drained", MEM_bypass_bus[38], 1'b1);
    step(0, idle, 1, 1, 0);
    step(0, idle, 0, 1, 0);
    chk("after_discard_result", ms_to_ws_bus[31:0], 32'h11111111);
    step(0, idle, 0, 1, 0);

    // asynchronous reset while a load waits behind a stale response
    step(1, mk(1, 3'b010, 0, 1, 5'd8, 32'h00006000, $urandom()), 0, 1, 0);
    step(0, idle, 0, 1, 1);
    step(1, mk(1, 3'b010, 0, 1, 5'd8, 32'h00007000, $urandom()), 0, 1, 0);
    step(0, idle, 0, 1, 0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("arst_valid", ms_to_ws_valid, 1'b0);
    chk("arst_allowin", ms_allowin, 1'b1);
    chk("arst_discard", dut.r_discard_cnt, 2'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = $urandom();
      #1;
      chk("arst_bypass", MEM_bypass_bus, 39'h0);
      chk("arst_ws_bus", ms_to_ws_bus, 71'h0);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    resetn = 1'b1;
    occ = 0; have = 0;
    resp_q.delete();
    exp_q.delete();
    ld_case("post_rst_ld", 3'b010, 32'h00008000, 32'h0BADF00D, 32'h0BADF00D);

    // random traffic
    have_cur = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!have_cur && $urandom_range(0, 9) < 7) begin
        cur = rnd_inst();
        have_cur = 1;
      end
      fl  = ($urandom_range(0, 19) == 0) && (stale_cnt() < 3);
      id0 = next_id;
      step(have_cur, cur, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, fl);
      if (next_id != id0 || fl) have_cur = 0;
    end

    for (int n = 0; n < 60 && (occ || resp_q.size() > 0); n++) step(0, idle, 1, 1, 0);
    step(0, idle, 0, 1, 0);
    #3;
    chk("drain_responses", resp_q.size(), 0);
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
